// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back / write-allocate L1 data cache controller.
// Each line holds 256 bits (eight 32-bit words) plus a {valid, dirty, tag} entry.
module l1_dcache_ctrl #(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned TAG_W     = 22
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [255:0] mem_data_o,
  output logic [31:0]  mem_addr_o,
  output logic         mem_enable_o,
  output logic         mem_write_o
);

  localparam int unsigned IdxW = $clog2(NUM_LINES);
  localparam int unsigned EntW = TAG_W + 2;  // {valid, dirty, tag}

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StMiss       = 3'd1;
  localparam logic [2:0] StWriteback  = 3'd2;
  localparam logic [2:0] StReadMiss   = 3'd3;
  localparam logic [2:0] StReadMissOk = 3'd4;

  logic [EntW-1:0] tag_q  [NUM_LINES];
  logic [255:0]    data_q [NUM_LINES];

  logic [2:0]   state_q, state_d;
  logic         mem_enable_q, mem_enable_d;
  logic         mem_write_q, mem_write_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [255:0] mem_data_q, mem_data_d;
  // Line address of the request that missed; the CPU may change or drop it mid-miss.
  logic [31:5]  miss_line_q, miss_line_d;

  logic [TAG_W-1:0] req_tag;
  logic [IdxW-1:0]  req_idx;
  logic [2:0]       req_word;
  logic             req_active, req_write, req_read;
  logic [EntW-1:0]  req_entry;
  logic [255:0]     req_line;
  logic             hit;
  logic [TAG_W-1:0] miss_tag;
  logic [IdxW-1:0]  miss_idx;
  logic [EntW-1:0]  victim_entry;
  logic             fill_en, wr_hit_en;
  logic             unused_addr;

  assign req_tag      = p1_addr_i[31 -: TAG_W];
  assign req_idx      = p1_addr_i[5 +: IdxW];
  assign req_word     = p1_addr_i[4:2];
  assign unused_addr  = ^p1_addr_i[1:0];
  assign req_active   = p1_MemRead_i | p1_MemWrite_i;
  assign req_write    = p1_MemWrite_i;  // read+write together counts as a write
  assign req_read     = p1_MemRead_i & ~p1_MemWrite_i;
  assign req_entry    = tag_q[req_idx];
  assign req_line     = data_q[req_idx];
  assign hit          = req_active & req_entry[EntW-1] & (req_entry[TAG_W-1:0] == req_tag);
  assign miss_tag     = miss_line_q[31 -: TAG_W];
  assign miss_idx     = miss_line_q[5 +: IdxW];
  assign victim_entry = tag_q[miss_idx];

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  // CPU-side outputs: read hits return data in the same cycle; any miss stalls at once.
  always_comb begin
    p1_data_o  = 32'h0;
    p1_stall_o = 1'b1;
    if (state_q == StIdle) begin
      p1_stall_o = req_active & ~hit;
      if (hit && req_read) begin
        p1_data_o = req_line[{req_word, 5'b0} +: 32];
      end
    end
  end

  // Next-state and registered memory-interface outputs.
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    miss_line_d  = miss_line_q;
    fill_en      = 1'b0;
    wr_hit_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hit && req_write) begin
          wr_hit_en = 1'b1;
        end else if (req_active && !hit) begin
          miss_line_d = p1_addr_i[31:5];
          state_d     = StMiss;
        end
      end
      StMiss: begin
        mem_enable_d = 1'b1;
        if (victim_entry[EntW-1] && victim_entry[EntW-2]) begin
          mem_write_d = 1'b1;
          mem_addr_d  = {victim_entry[TAG_W-1:0], miss_line_q[31-TAG_W:5], 5'b0};
          mem_data_d  = data_q[miss_idx];
          state_d     = StWriteback;
        end else begin
          mem_write_d = 1'b0;
          mem_addr_d  = {miss_line_q, 5'b0};
          state_d     = StReadMiss;
        end
      end
      StWriteback: begin
        if (mem_ack_i) begin
          mem_write_d = 1'b0;
          mem_addr_d  = {miss_line_q, 5'b0};
          state_d     = StReadMiss;
        end
      end
      StReadMiss: begin
        if (mem_ack_i) begin
          fill_en      = 1'b1;
          mem_enable_d = 1'b0;
          state_d      = StReadMissOk;
        end
      end
      StReadMissOk: state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  // Control and memory-interface registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_data_q   <= 256'h0;
      miss_line_q  <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      miss_line_q  <= miss_line_d;
    end
  end

  // Tag array: reset clears only valid/dirty so stored tags survive for preloading.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i][EntW-1 -: 2] <= 2'b00;
      end
    end else if (fill_en) begin
      tag_q[miss_idx] <= {2'b10, miss_tag};
    end else if (wr_hit_en) begin
      tag_q[req_idx][EntW-2] <= 1'b1;
    end
  end

  // Data array: line fill from memory or word merge on a store hit; never reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fill_en) begin
        data_q[miss_idx] <= mem_data_i;
      end else if (wr_hit_en) begin
        data_q[req_idx][{req_word, 5'b0} +: 32] <= p1_data_i;
      end
    end
  end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed bench for l1_dcache_ctrl: loads are scoreboarded, memory is driven by hand.
module tb_l1_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  p1_addr;
  logic [31:0]  p1_wdata;
  logic         p1_rd;
  logic         p1_wr;
  logic [31:0]  p1_rdata;
  logic         p1_stall;
  logic [255:0] mem_rdata;
  logic         mem_ack;
  logic [255:0] mem_wdata;
  logic [31:0]  mem_addr;
  logic         mem_en;
  logic         mem_we;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  l1_dcache_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .p1_addr_i     (p1_addr),
    .p1_data_i     (p1_wdata),
    .p1_MemRead_i  (p1_rd),
    .p1_MemWrite_i (p1_wr),
    .p1_data_o     (p1_rdata),
    .p1_stall_o    (p1_stall),
    .mem_data_i    (mem_rdata),
    .mem_ack_i     (mem_ack),
    .mem_data_o    (mem_wdata),
    .mem_addr_o    (mem_addr),
    .mem_enable_o  (mem_en),
    .mem_write_o   (mem_we)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs are driven and outputs sampled after the falling edge.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // One cycle with mem_ack high.
  task automatic do_ack();
    mem_ack = 1'b1;
    nxt();
    mem_ack = 1'b0;
    #1;
  endtask

  // Bounded wait for the stall to drop, then retire the oldest expected load.
  task automatic wait_load(input string tag);
    logic [31:0] exp;
    int n = 0;
    while (p1_stall && n < 20) begin
      nxt();
      #1;
      n++;
    end
    check({tag, "_nostall"}, p1_stall, 1'b0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_data"}, p1_rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; p1_addr = 32'h0; p1_wdata = 32'h0; p1_rd = 1'b0; p1_wr = 1'b0;
    mem_rdata = 256'h0; mem_ack = 1'b0;
    nxt(); nxt();
    rst = 1'b0;
    #1;
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_stall", p1_stall, 1'b0);
    check("rst_rdata", p1_rdata, 32'h0);

    // Cold read miss of address 0, line filled with 0x5.
    nxt();
    mem_rdata = 256'h5;
    p1_addr = 32'h0; p1_rd = 1'b1;
    #1;
    check("miss0_stall_same_cycle", p1_stall, 1'b1);
    exp_q.push_back(32'h0000_0005);
    nxt();
    check("miss0_in_miss_no_en", mem_en, 1'b0);
    nxt();
    check("miss0_rm_en", mem_en, 1'b1);
    check("miss0_rm_we", mem_we, 1'b0);
    check("miss0_rm_addr", mem_addr, 32'h0);
    do_ack();
    check("miss0_ok_en_low", mem_en, 1'b0);
    check("miss0_ok_stall", p1_stall, 1'b1);
    wait_load("miss0");
    p1_rd = 1'b0;
    #1;
    check("no_read_rdata_zero", p1_rdata, 32'h0);

    // Store hit: merged at the next edge, no memory traffic.
    p1_addr = 32'h4; p1_wdata = 32'hDEAD_BEEF; p1_wr = 1'b1;
    #1;
    check("wr_hit_stall", p1_stall, 1'b0);
    check("wr_hit_mem_en", mem_en, 1'b0);
    nxt();
    p1_wr = 1'b0;
    #1;
    check("wr_hit_word1", dut.data_q[0][63:32], 32'hDEAD_BEEF);
    check("wr_hit_dirty", dut.tag_q[0][22], 1'b1);
    check("wr_hit_mem_en_after", mem_en, 1'b0);

    // Conflict miss on dirty line 0: write-back then fill.
    mem_rdata = 256'hCAFE_F00D;
    p1_addr = 32'h400; p1_rd = 1'b1;
    #1;
    exp_q.push_back(32'hCAFE_F00D);
    check("wb_stall", p1_stall, 1'b1);
    nxt(); nxt();
    check("wb_en", mem_en, 1'b1);
    check("wb_we", mem_we, 1'b1);
    check("wb_addr", mem_addr, 32'h0);
    check("wb_data_word1", mem_wdata[63:32], 32'hDEAD_BEEF);
    check("wb_data_word0", mem_wdata[31:0], 32'h5);
    nxt();
    check("wb_hold_we", mem_we, 1'b1);
    check("wb_hold_en", mem_en, 1'b1);
    do_ack();
    check("wb2rm_en", mem_en, 1'b1);
    check("wb2rm_we", mem_we, 1'b0);
    check("wb2rm_addr", mem_addr, 32'h400);
    do_ack();
    wait_load("fill400");
    check("fill400_tag", dut.tag_q[0][21:0], 22'h1);
    check("fill400_dirty", dut.tag_q[0][22], 1'b0);
    check("fill400_valid", dut.tag_q[0][23], 1'b1);
    p1_rd = 1'b0;

    // Stray ack while idle is ignored.
    mem_ack = 1'b1;
    nxt();
    mem_ack = 1'b0;
    #1;
    check("stray_ack_en", mem_en, 1'b0);

    // Clean (invalid) line 1: straight to READMISS, no write-back.
    mem_rdata = {224'h0, 32'h1234_5678};
    p1_addr = 32'h20; p1_rd = 1'b1;
    #1;
    exp_q.push_back(32'h1234_5678);
    nxt(); nxt();
    check("clean_rm_en", mem_en, 1'b1);
    check("clean_rm_we", mem_we, 1'b0);
    check("clean_rm_addr", mem_addr, 32'h20);
    do_ack();
    wait_load("clean20");
    p1_rd = 1'b0;

    // Read+write together behaves as a store.
    p1_addr = 32'h24; p1_wdata = 32'h0BAD_F00D; p1_rd = 1'b1; p1_wr = 1'b1;
    #1;
    check("rw_stall", p1_stall, 1'b0);
    check("rw_no_rdata", p1_rdata, 32'h0);
    nxt();
    p1_wr = 1'b0;
    #1;
    check("rw_read_back", p1_rdata, 32'h0BAD_F00D);
    check("rw_read_stall", p1_stall, 1'b0);
    p1_rd = 1'b0;

    // Request dropped mid-miss still fills line 3.
    mem_rdata = {224'h0, 32'h0000_3333};
    p1_addr = 32'h60; p1_rd = 1'b1;
    nxt();
    p1_rd = 1'b0;
    nxt();
    check("drop_rm_en", mem_en, 1'b1);
    check("drop_rm_addr", mem_addr, 32'h60);
    do_ack();
    nxt();
    check("drop_idle_stall", p1_stall, 1'b0);
    check("drop_valid", dut.tag_q[3][23], 1'b1);
    p1_addr = 32'h60; p1_rd = 1'b1;
    #1;
    check("drop_hit_data", p1_rdata, 32'h0000_3333);
    p1_rd = 1'b0;

    // Reset during READMISS of line 2 aborts the fill.
    p1_addr = 32'h40; p1_rd = 1'b1;
    nxt(); nxt();
    check("abort_rm_en", mem_en, 1'b1);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    p1_rd = 1'b0;
    #1;
    check("abort_en_low", mem_en, 1'b0);
    check("abort_idle_stall", p1_stall, 1'b0);
    check("abort_line2_invalid", dut.tag_q[2][23], 1'b0);
    nxt();
    check("abort_stays_idle_en", mem_en, 1'b0);

    // Line 1 still holds tag 0 but valid was cleared: must miss.
    mem_rdata = {224'h0, 32'h0000_7777};
    p1_addr = 32'h20; p1_rd = 1'b1;
    #1;
    check("postrst_tag0_miss", p1_stall, 1'b1);
    exp_q.push_back(32'h0000_7777);
    nxt(); nxt();
    check("postrst_rm_addr", mem_addr, 32'h20);
    do_ack();
    wait_load("postrst20");
    p1_rd = 1'b0;
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l1_dcache_ctrl.md
L1_DCACHE_CTRL -- requirements
Module: l1_dcache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, 32, number of direct-mapped lines, each 256 bits.
REQ-002 SHALL have parameter TAG_W, 22, address tag width taken from addr[31:10].
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port p1_addr_i, input, 32, CPU byte address.
REQ-006 SHALL have port p1_data_i, input, 32, CPU store data.
REQ-007 SHALL have port p1_MemRead_i, input, 1, load request.
REQ-008 SHALL have port p1_MemWrite_i, input, 1, store request.
REQ-009 SHALL have port p1_data_o, output, 32, load data.
REQ-010 SHALL have port p1_stall_o, output, 1, pipeline stall.
REQ-011 SHALL have port mem_data_i, input, 256, memory line read data.
REQ-012 SHALL have port mem_ack_i, input, 1, memory transfer complete.
REQ-013 SHALL have port mem_data_o, output, 256, write-back line.
REQ-014 SHALL have port mem_addr_o, output, 32, line-aligned memory address.
REQ-015 SHALL have port mem_enable_o, output, 1, memory request.
REQ-016 SHALL have port mem_write_o, output, 1, 1 = write and 0 = read.

Function
REQ-017 SHALL decode the address as tag = addr[31:10], index = addr[9:5], word = addr[4:2]; addr[1:0] is ignored.
REQ-018 SHALL hold per line a 24-bit tag entry {valid, dirty, tag[21:0]} and a 256-bit data entry; word w occupies bits [32w+31:32w].
REQ-019 SHALL define a hit as request active, line valid, and stored tag equal to request tag.
REQ-020 SHALL use a write-back, write-allocate policy.
REQ-021 SHALL implement the states IDLE, MISS, WRITEBACK, READMISS and READMISSOK.
REQ-022 SHALL, in IDLE on a read hit, drive p1_data_o combinationally with the selected word in the same cycle, with p1_stall_o = 0.
REQ-023 SHALL, in IDLE on a write hit, merge p1_data_i into the selected word and set dirty at the next edge, with p1_stall_o = 0 and no memory access.
REQ-024 SHALL, in IDLE on a miss, drive p1_stall_o = 1 combinationally in the same cycle and move to MISS at the next edge.
REQ-025 SHALL drive p1_stall_o = 1 in MISS, WRITEBACK, READMISS and READMISSOK.
REQ-026 SHALL, in MISS with the victim dirty, move to WRITEBACK with registered outputs: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {old tag, index, 5'b0}, mem_data_o = victim line.
REQ-027 SHALL, in MISS with the victim clean or invalid, move to READMISS with mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}.
REQ-028 SHALL, in WRITEBACK, hold all memory outputs until mem_ack_i; on ack, move to READMISS with mem_write_o = 0, the address switched to the fill address, and mem_enable_o kept at 1.
REQ-029 SHALL, in READMISS on mem_ack_i, write mem_data_i to the line with tag = req tag, valid = 1, dirty = 0; deassert mem_enable_o; and move to READMISSOK.
REQ-030 SHALL move from READMISSOK to IDLE unconditionally after one cycle; the pending request then completes as a hit per REQ-022/023.
REQ-031 SHALL ignore mem_ack_i outside WRITEBACK and READMISS.
REQ-032 SHALL treat MemRead and MemWrite asserted together as a write.
REQ-033 SHALL drive p1_data_o = 0 when no read is active.
REQ-034 SHALL, if the request drops during a miss, still complete the fill and return to IDLE.
REQ-035 SHALL keep mem_enable_o continuously high from entry into WRITEBACK or READMISS until the READMISS ack.

Reset
REQ-036 SHALL, on rst_i = 1 at a clock edge, set the state to IDLE; clear mem_enable_o, mem_write_o, mem_addr_o and mem_data_o to 0; and clear every valid and dirty bit.
REQ-037 SHALL NOT clear the tag[21:0] fields or the data array on reset, so the bench can preload them.
REQ-038 SHALL, on reset mid-operation (any state), abort the operation, deassert mem_enable_o at that edge, and leave the line being filled invalid.

Verification
REQ-039 SHALL be verified by: reset, memory line 0 = 0x5, read 0x00000000 -> stall rises the same cycle; READMISS address 0x00000000 with write = 0; p1_data_o = 0x00000005 and stall = 0 two cycles after the ack cycle.
REQ-040 SHALL be verified by: after the fill, write 0x00000004 with 0xDEADBEEF -> no stall, no mem_enable_o, line 0 bits [63:32] = DEADBEEF, dirty = 1.
REQ-041 SHALL be verified by: then read 0x00000400 -> WRITEBACK with mem_addr_o = 0x00000000, mem_write_o = 1, mem_data_o[63:32] = DEADBEEF; after the ack, READMISS with mem_addr_o = 0x00000400 and write = 0; line 0 tag = 1, dirty = 0.
REQ-042 SHALL be verified by: read 0x00000020 to clean line 1 -> no WRITEBACK; READMISS is entered directly from MISS.
REQ-043 SHALL be verified by: right after reset with tag entries preloaded to 0, read 0x00000000 -> miss despite the tag match, because valid = 0.
REQ-044 SHALL be verified by: rst_i asserted in READMISS -> mem_enable_o = 0 after that edge and state IDLE; a subsequent read of 0x00000020 misses again.
